// File: rtl/prim_flop_rd_ser_pkg.sv
// Shared types and sizing helpers for the flop-register read serializer.
// Beat order is selected in the top by PRIM_FLOP_RD_SER_MSB_FIRST_EN.
package prim_flop_rd_ser_pkg;

  typedef enum logic [0:0] {
    RdSerIdle = 1'b0,
    RdSerSend = 1'b1
  } rd_ser_state_e;

  function automatic int unsigned num_beats(input int unsigned width,
                                            input int unsigned beat_width);
    return (width + beat_width - 1) / beat_width;
  endfunction

  // A beat counter still needs one bit when there is only a single beat.
  function automatic int unsigned idx_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/prim_flop_rd_ser_hold.sv
// Snapshot register for the read serializer: loads the zero-extended source
// value when a request is accepted and holds it for the whole transfer.
module prim_flop_rd_ser_hold
  import prim_flop_rd_ser_pkg::*;
#(
  parameter int unsigned HoldWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load,
  input  logic [HoldWidth-1:0] d,
  output logic [HoldWidth-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/prim_flop_rd_serializer.sv
// Snapshots a Width-bit register on request and streams it out as NumBeats
// BeatWidth-bit beats over valid/ready. Define PRIM_FLOP_RD_SER_MSB_FIRST_EN
// to emit the most-significant beat first.
module prim_flop_rd_serializer
  import prim_flop_rd_ser_pkg::*;
#(
  parameter int unsigned Width     = 32,
  parameter int unsigned BeatWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [Width-1:0]     d_i,
  output logic                 busy_o,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [BeatWidth-1:0] beat_data_o,
  output logic                 beat_last_o,
  output logic                 done_o,
  output logic                 req_err_o
);

  localparam int unsigned NumBeats  = num_beats(Width, BeatWidth);
  localparam int unsigned HoldWidth = NumBeats * BeatWidth;
  localparam int unsigned IdxWidth  = idx_width(NumBeats);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBeats - 1);

  localparam logic [0:0] StIdle = RdSerIdle;
  localparam logic [0:0] StSend = RdSerSend;

  if (Width < 1) begin : gen_bad_width
    $error("Width must be at least 1");
  end
  if (BeatWidth < 1 || BeatWidth > Width) begin : gen_bad_beat_width
    $error("BeatWidth must be in 1..Width");
  end

  logic [0:0]          state_q;
  logic [IdxWidth-1:0] beat_idx_q;
  logic                done_q;
  logic                load;
  logic                handshake;
  logic [HoldWidth-1:0] d_ext;
  logic [HoldWidth-1:0] hold_q;
  logic [BeatWidth-1:0] beat_cur;

  assign d_ext = HoldWidth'(d_i);
  assign load  = (state_q == StIdle) & req_i;

  prim_flop_rd_ser_hold #(
    .HoldWidth(HoldWidth)
  ) u_hold (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load  (load),
    .d     (d_ext),
    .q     (hold_q)
  );

  // Beat selection: the counter always runs 0..NumBeats-1; only the slice it
  // addresses depends on the configured order.
  if (NumBeats == 1) begin : gen_single_beat
    assign beat_cur = hold_q;
  end else begin : gen_multi_beat
    logic [NumBeats-1:0][BeatWidth-1:0] beats;
    logic [IdxWidth-1:0]                sel;

    assign beats = hold_q;

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to remember the old value.
    always_comb begin
`ifdef PRIM_FLOP_RD_SER_MSB_FIRST_EN
      sel = LastIdx - beat_idx_q;
`else
      sel = beat_idx_q;
`endif
    end

    assign beat_cur = beats[sel];
  end

  assign busy_o       = (state_q == StSend);
  assign beat_valid_o = busy_o;
  assign beat_data_o  = busy_o ? beat_cur : '0;
  assign beat_last_o  = busy_o & (beat_idx_q == LastIdx);
  assign req_err_o    = busy_o & req_i;
  assign done_o       = done_q;
  assign handshake    = beat_valid_o & beat_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      beat_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            state_q    <= StSend;
            beat_idx_q <= '0;
          end
        end
        StSend: begin
          if (handshake) begin
            if (beat_last_o) begin
              state_q    <= StIdle;
              beat_idx_q <= '0;
              done_q     <= 1'b1;
            end else begin
              beat_idx_q <= beat_idx_q + IdxWidth'(1);
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          beat_idx_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prim_flop_rd_serializer.sv
// Self-checking bench for prim_flop_rd_serializer: vector table, corner-case
// sequences and randomized transfers against a shift-based reference model.
module tb_prim_flop_rd_serializer;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32/8 instance
  logic        req_a = 1'b0;
  logic [31:0] d_a = '0;
  logic        ready_a = 1'b0;
  logic        busy_a, valid_a, last_a, done_a, err_a;
  logic [7:0]  data_a;

  // 12/8 instance (padded last beat)
  logic        req_b = 1'b0;
  logic [11:0] d_b = '0;
  logic        ready_b = 1'b0;
  logic        busy_b, valid_b, last_b, done_b, err_b;
  logic [7:0]  data_b;

  int checks = 0;
  int failures = 0;

  prim_flop_rd_serializer #(.Width(32), .BeatWidth(8)) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_a),
    .d_i         (d_a),
    .busy_o      (busy_a),
    .beat_valid_o(valid_a),
    .beat_ready_i(ready_a),
    .beat_data_o (data_a),
    .beat_last_o (last_a),
    .done_o      (done_a),
    .req_err_o   (err_a)
  );

  prim_flop_rd_serializer #(.Width(12), .BeatWidth(8)) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_b),
    .d_i         (d_b),
    .busy_o      (busy_b),
    .beat_valid_o(valid_b),
    .beat_ready_i(ready_b),
    .beat_data_o (data_b),
    .beat_last_o (last_b),
    .done_o      (done_b),
    .req_err_o   (err_b)
  );

  typedef struct {
    logic [31:0]     d;
    logic [3:0][7:0] lsb;  // expected beats in LSB-first order, [0] first
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: beat k of a transfer is byte pos of the zero-extended value.
  function automatic logic [7:0] model_beat(input logic [31:0] val, input int k, input int nbeats);
    int pos;
`ifdef PRIM_FLOP_RD_SER_MSB_FIRST_EN
    pos = nbeats - 1 - k;
`else
    pos = k;
`endif
    return 8'((val >> (8 * pos)) & 32'hFF);
  endfunction

  function automatic logic [7:0] table_beat(input logic [3:0][7:0] lsb, input int k);
`ifdef PRIM_FLOP_RD_SER_MSB_FIRST_EN
    return lsb[NB-1-k];
`else
    return lsb[k];
`endif
  endfunction

  task automatic check_idle_a(input string name);
    check({name, "_busy"}, busy_a, 0);
    check({name, "_valid"}, valid_a, 0);
    check({name, "_data"}, data_a, 0);
    check({name, "_last"}, last_a, 0);
  endtask

  // One full transfer on instance A; optional stall on one beat and optional
  // req_i held high (with d_i zeroed) throughout Send.
  task automatic xfer_a(input logic [31:0] val, input logic [3:0][7:0] lsb,
                        input int stall_beat, input int stall_n, input bit req_in_send);
    logic [7:0] e;
    @(negedge clk);
    req_a = 1'b1; d_a = val; ready_a = 1'b1;
    #1 check("req_idle_err", err_a, 0);
    @(negedge clk);
    req_a = req_in_send; d_a = 32'h0;
    for (int k = 0; k < NB; k++) begin
      e = table_beat(lsb, k);
      if (k == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          ready_a = 1'b0;
          #1;
          check("stall_valid", valid_a, 1);
          check("stall_data", data_a, e);
          check("stall_last", last_a, (k == NB - 1));
          @(negedge clk);
        end
      end
      ready_a = 1'b1;
      #1;
      check("beat_valid", valid_a, 1);
      check("beat_data", data_a, e);
      check("beat_last", last_a, (k == NB - 1));
      check("beat_err", err_a, req_in_send);
      check("beat_done", done_a, 0);
      @(negedge clk);
    end
    req_a = 1'b0;
    #1;
    check("done_pulse", done_a, 1);
    check_idle_a("after_xfer");
  endtask

  logic [31:0] val;
  logic [31:0] val2;
  int          got;
  int          cyc;

  initial begin
    vecs[0] = '{32'hA1B2C3D4, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    vecs[1] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{32'hFFFFFFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[3] = '{32'h12345678, {8'h12, 8'h34, 8'h56, 8'h78}};
    vecs[4] = '{32'h80000001, {8'h80, 8'h00, 8'h00, 8'h01}};

    // Reset state
    #12;
    check_idle_a("reset");
    check("reset_done", done_a, 0);
    check("reset_err", err_a, 0);
    check("reset_b_valid", valid_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, full throughput
    for (int i = 0; i < 5; i++) xfer_a(vecs[i].d, vecs[i].lsb, -1, 0, 1'b0);

    // Stall three cycles on beat 1
    xfer_a(vecs[0].d, vecs[0].lsb, 1, 3, 1'b0);
    // Stall on the last beat
    xfer_a(vecs[3].d, vecs[3].lsb, 3, 2, 1'b0);
    // req_i held during Send with d_i cleared
    xfer_a(vecs[0].d, vecs[0].lsb, 2, 1, 1'b1);

    // Back-to-back: request in the cycle done_o is high
    xfer_a(vecs[3].d, vecs[3].lsb, -1, 0, 1'b0);
    val2 = 32'hCAFEF00D;
    req_a = 1'b1; d_a = val2;
    @(negedge clk);
    req_a = 1'b0;
    for (int k = 0; k < NB; k++) begin
      #1;
      check("b2b_valid", valid_a, 1);
      check("b2b_data", data_a, model_beat(val2, k, NB));
      @(negedge clk);
    end
    #1 check("b2b_done", done_a, 1);

    // Reset asserted while beat 1 of 4 is presented
    @(negedge clk);
    req_a = 1'b1; d_a = vecs[0].d; ready_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    #1 check("pre_rst_data", data_a, model_beat(vecs[0].d, 1, NB));
    #1 rst_n = 1'b0;
    #1;
    check_idle_a("async_rst");
    check("async_rst_done", done_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", valid_a, 0);
      check("post_rst_done", done_a, 0);
    end

    // Padded 12-bit value on instance B
    @(negedge clk);
    req_b = 1'b1; d_b = 12'hABC; ready_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    #1;
`ifdef PRIM_FLOP_RD_SER_MSB_FIRST_EN
    check("pad_beat0", data_b, 8'h0A);
`else
    check("pad_beat0", data_b, 8'hBC);
`endif
    check("pad_last0", last_b, 0);
    @(negedge clk);
    #1;
`ifdef PRIM_FLOP_RD_SER_MSB_FIRST_EN
    check("pad_beat1", data_b, 8'hBC);
`else
    check("pad_beat1", data_b, 8'h0A);
`endif
    check("pad_last1", last_b, 1);
    @(negedge clk);
    #1 check("pad_done", done_b, 1);

    // Randomized transfers with random back-pressure and stray requests
    for (int it = 0; it < 30; it++) begin
      val = $urandom;
      @(negedge clk);
      req_a = 1'b1; d_a = val; ready_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = 0;
      cyc = 0;
      while (got < NB && cyc < 200) begin
        ready_a = 1'($urandom_range(0, 1));
        req_a   = 1'($urandom_range(0, 1));
        d_a     = $urandom;
        #1;
        check("rand_valid", valid_a, 1);
        check("rand_data", data_a, model_beat(val, got, NB));
        check("rand_last", last_a, (got == NB - 1));
        check("rand_err", err_a, req_a);
        if (ready_a) got++;
        @(negedge clk);
        cyc++;
      end
      check("rand_beats", got, NB);
      req_a = 1'b0;
      #1 check("rand_done", done_a, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prim_flop_rd_serializer.md
Name: prim_flop_rd_serializer

Overview:
Read-side companion to the enable-flop register primitive. On a request it snapshots a wide register value (Width bits) and streams it out as NumBeats narrow beats over a valid/ready interface. It is used wherever a wide configuration or status register must be read back over a narrow datapath, such as debug readback or a narrow TL-UL shim. The block is fully synchronous to clk_i, apart from the asynchronous reset.

Parameters:
Width, 32, bit width of the source register value d_i; must be >= 1.
BeatWidth, 8, bit width of one output beat; must satisfy 1 <= BeatWidth <= Width.
NumBeats, derived (ceil(Width/BeatWidth)), number of beats per transfer; localparam, not overridable.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  asynchronous active-low reset.
req_i  input  1  capture request; sampled only in Idle.
d_i  input  Width  register value to snapshot.
busy_o  output  1  high while a transfer is in progress (state Send).
beat_valid_o  output  1  beat available.
beat_ready_i  input  1  downstream accepts beat.
beat_data_o  output  BeatWidth  current beat.
beat_last_o  output  1  current beat is the final beat.
done_o  output  1  one-cycle pulse in the cycle after the last beat handshake.
req_err_o  output  1  one-cycle pulse when req_i is high while busy_o is high.

Behaviour:
- Reset and clock: rst_ni is an asynchronous, active-low reset; the clock is clk_i.
- Reset values: state=Idle; holding register=0; beat_idx=0; all outputs 0.
- FSM states: Idle, Send.
- Idle -> Send: on req_i=1.
  - Capture d_i into the holding register, zero-extended to NumBeats*BeatWidth.
  - Set beat_idx=0.
  - beat_valid_o asserts on the next cycle (latency 1 from req_i to the first valid beat).
- Send:
  - beat_valid_o=1 and busy_o=1.
  - beat_data_o = hold[beat_idx*BeatWidth +: BeatWidth].
  - beat_last_o = (beat_idx == NumBeats-1).
- Handshake: a beat transfers when beat_valid_o & beat_ready_i.
  - Not last beat: beat_idx increments.
  - Last beat: go to Idle, beat_idx=0, done_o=1 in the following cycle.
- Stall: beat_data_o and beat_last_o stay stable while beat_valid_o=1 & beat_ready_i=0. No beat is ever dropped or repeated.
- Throughput: one beat per cycle while beat_ready_i is held high. A transfer takes NumBeats cycles after the first valid beat.
- Back-to-back requests:
  - req_i in the same cycle done_o is high: accepted (state is Idle).
  - Consequence: minimum one Idle cycle between transfers.
- req_i in Send: ignored and the snapshot is unchanged; req_err_o pulses for 1 cycle per such cycle.
- d_i changes after capture: no effect on the transfer in progress.
- Padding: when Width is not a multiple of BeatWidth, the upper bits of the last beat are 0.
- Single-beat case (NumBeats=1): beat_last_o=1 on the only beat; beat_idx width clamps to 1 bit.
- beat_ready_i in Idle: ignored.
- Reset mid-transfer: rst_ni low aborts immediately and asynchronously.
  - Outputs go to reset values.
  - No done_o pulse and no partial beats after reset release.

Optional Feature:
Macro PRIM_FLOP_RD_SER_MSB_FIRST_EN.
- Defined: beats are emitted most-significant first, so beat k carries hold[(NumBeats-1-k)*BeatWidth +: BeatWidth]. Zero padding then appears in the first beat.
- Undefined (default): LSB-first ordering, as described above.
- Handshake, timing and error behaviour are identical in both cases.

Decomposition:
- Package prim_flop_rd_ser_pkg:
  - state enum rd_ser_state_e {RdSerIdle, RdSerSend}, 1-bit encoding.
  - function num_beats(width, beat_width) returning ceil(width/beat_width).
- Sub-module prim_flop_rd_ser_hold: enabled capture register, NumBeats*BeatWidth wide, with async reset to 0 and load enable = (state==Idle & req_i).
- The FSM, beat counter and beat mux stay in the top module.

Test Plan:
- Width=32, BeatWidth=8, d_i=0xA1B2C3D4, req pulse, ready=1 -> beats 0xD4,0xC3,0xB2,0xA1 on 4 consecutive cycles; last on 0xA1; done_o next cycle.
- Same stimulus with ready low for 3 cycles on beat 1 -> 0xC3 held stable for 4 cycles; no duplicate or lost beats.
- Width=12, BeatWidth=8, d_i=0xABC -> beats 0xBC, 0x0A; with PRIM_FLOP_RD_SER_MSB_FIRST_EN -> 0x0A, 0xBC.
- req_i high during Send, d_i changed to 0x0 -> req_err_o pulses each such cycle; original beats still emitted.
- Assert rst_ni low after beat 1 of 4 -> all outputs 0 immediately; after release, no beats and no done_o until a new req.
- req_i coincident with done_o -> new transfer accepted; first beat valid on the next cycle.
